pll_lock_sequencer: RTL and testbench

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_lock_sequencer.sv | 100 ++++++++++
 tb/tb_pll_lock_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: resets the PLL, waits for a synchronized lock, qualifies it
// for a stable window, then releases the downstream reset; gives up after repeated timeouts.
module pll_lock_sequencer #(
    parameter int RST_CYCLES     = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       req,
    output logic       ack,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retries
);

    localparam logic [23:0] RST_LAST    = 24'(RST_CYCLES - 1);
    localparam logic [23:0] STABLE_LAST = 24'(STABLE_CYCLES - 1);
    localparam logic [23:0] TO_LAST     = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {S_PRST, S_WAIT, S_STABLE, S_RUN, S_FAIL} state_t;

    state_t      state, nxt;
    logic [23:0] cnt;
    logic [1:0]  sync_q;
    logic        lock;
    logic        ack_nxt;
    logic [3:0]  retries_nxt;
    logic [3:0]  retries_inc;

    assign lock        = sync_q[1];
    assign retries_inc = retries + 4'd1;

    always_comb begin
        nxt         = state;
        ack_nxt     = 1'b0;
        retries_nxt = retries;
        case (state)
            S_PRST:   if (cnt == RST_LAST) nxt = S_WAIT;
            S_WAIT: begin
                if (lock) begin
                    nxt = S_STABLE;
                end else if (cnt == TO_LAST) begin
                    retries_nxt = retries_inc;
                    nxt         = (retries_inc == RETRY_LIMIT) ? S_FAIL : S_PRST;
                end
            end
            S_STABLE: begin
                if (!lock)                    nxt = S_WAIT;
                else if (cnt == STABLE_LAST)  nxt = S_RUN;
            end
            S_RUN, S_FAIL: begin
                // A request outranks a simultaneous lock loss so the requester always sees ack.
                if (req) begin
                    nxt         = S_PRST;
                    ack_nxt     = 1'b1;
                    retries_nxt = 4'd0;
                end else if (state == S_RUN && !lock) begin
                    nxt = S_PRST;
                end
            end
            default:  nxt = S_PRST;
        endcase
        if (nxt == S_RUN) retries_nxt = 4'd0;
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state     <= S_PRST;
            cnt       <= '0;
            sync_q    <= '0;
            ack       <= 1'b0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fail      <= 1'b0;
            retries   <= 4'd0;
        end else begin
            sync_q    <= {sync_q[0], pll_locked};
            state     <= nxt;
            if (nxt != state)
                cnt <= '0;
            else if (state == S_PRST || state == S_WAIT || state == S_STABLE)
                cnt <= cnt + 24'd1;
            ack       <= ack_nxt;
            pll_rst   <= (nxt == S_PRST) || (nxt == S_FAIL);
            sys_rst_n <= (nxt == S_RUN);
            ready     <= (nxt == S_RUN);
            fail      <= (nxt == S_FAIL);
            retries   <= retries_nxt;
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer; inputs are driven and outputs sampled on the
// falling edge, scheduled against an absolute rising-edge count.
module tb_pll_lock_sequencer;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       req = 1'b0;
    logic       ack, pll_rst, sys_rst_n, ready, fail;
    logic [3:0] retries;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    pll_lock_sequencer #(
        .RST_CYCLES(4), .STABLE_CYCLES(8), .TIMEOUT_CYCLES(32), .MAX_RETRIES(2)
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .req(req),
        .ack(ack), .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready),
        .fail(fail), .retries(retries)
    );

    always #5 refclk = ~refclk;
    always @(posedge refclk) cyc <= cyc + 1;

    // Advance to the falling edge that follows rising edge number k.
    task automatic at(input int k);
        repeat (k - cyc) @(negedge refclk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        else n_pass++;
    endtask

    initial begin
        // reset
        at(2);
        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_sys_rst_n", sys_rst_n, 0);
        chk("rst_ready", ready, 0);
        chk("rst_fail", fail, 0);
        chk("rst_ack", ack, 0);
        chk("rst_retries", retries, 0);
        rst_n = 1'b1;
        at(5);   chk("prst_hold", pll_rst, 1);
        at(6);   chk("prst_release", pll_rst, 0);
                 chk("wait_sys_rst_n", sys_rst_n, 0);

        // nominal lock
        at(15);  pll_locked = 1'b1;
        at(25);  chk("nom_ready_early", ready, 0);
        at(26);  chk("nom_ready", ready, 1);
                 chk("nom_sys_rst_n", sys_rst_n, 1);
                 chk("nom_pll_rst", pll_rst, 0);
                 chk("nom_retries", retries, 0);

        // lock loss in RUN
        at(29);  pll_locked = 1'b0;
        at(31);  chk("loss_still_run", sys_rst_n, 1);
        at(32);  chk("loss_sys_rst_n", sys_rst_n, 0);
                 chk("loss_pll_rst", pll_rst, 1);
                 chk("loss_retries", retries, 0);
                 chk("loss_no_ack", ack, 0);
        at(35);  chk("loss_prst_hold", pll_rst, 1);
        at(36);  chk("loss_prst_end", pll_rst, 0);

        // one-cycle lock glitch during STABLE
        at(37);  pll_locked = 1'b1;
        at(42);  pll_locked = 1'b0;
        at(43);  pll_locked = 1'b1;
        at(48);  chk("glitch_no_run", ready, 0);
        at(53);  chk("glitch_ready_early", ready, 0);
        at(54);  chk("glitch_ready", ready, 1);
                 chk("glitch_retries", retries, 0);

        // plain request in RUN
        at(55);  req = 1'b1;
        at(56);  chk("req_run_ack", ack, 1);
                 chk("req_run_pll_rst", pll_rst, 1);
                 req = 1'b0;
        at(57);  chk("req_run_ack_pulse", ack, 0);

        // request raised in WAIT is held off until RUN
        at(60);  req = 1'b1;
        at(61);  chk("req_wait_no_ack", ack, 0);
        at(68);  chk("req_stable_no_ack", ack, 0);
                 chk("req_stable_ready", ready, 0);
        at(69);  chk("req_run_entry", ready, 1);
                 chk("req_run_entry_ack", ack, 0);
        at(70);  chk("req_late_ack", ack, 1);
                 chk("req_late_ready", ready, 0);
                 chk("req_late_pll_rst", pll_rst, 1);
                 req = 1'b0;
        at(71);  chk("req_late_ack_pulse", ack, 0);

        // request coincident with lock loss
        at(83);  chk("both_run", ready, 1);
                 pll_locked = 1'b0;
        at(85);  chk("both_still_run", ready, 1);
                 req = 1'b1;
        at(86);  chk("both_ack", ack, 1);
                 chk("both_pll_rst", pll_rst, 1);
                 chk("both_sys_rst_n", sys_rst_n, 0);
                 req = 1'b0;
        at(87);  chk("both_ack_pulse", ack, 0);

        // lock timeouts to FAIL
        at(121); chk("to1_pre_retries", retries, 0);
                 chk("to1_pre_pll_rst", pll_rst, 0);
        at(122); chk("to1_retries", retries, 1);
                 chk("to1_pll_rst", pll_rst, 1);
                 chk("to1_fail", fail, 0);
        at(157); chk("to2_pre_fail", fail, 0);
                 chk("to2_pre_retries", retries, 1);
        at(158); chk("to2_fail", fail, 1);
                 chk("to2_retries", retries, 2);
                 chk("to2_pll_rst", pll_rst, 1);
                 chk("to2_sys_rst_n", sys_rst_n, 0);
                 chk("to2_ready", ready, 0);
        at(168); chk("fail_hold", fail, 1);
                 chk("fail_pll_rst_hold", pll_rst, 1);
                 req = 1'b1;
        at(169); chk("fail_req_ack", ack, 1);
                 chk("fail_req_retries", retries, 0);
                 chk("fail_req_fail", fail, 0);
                 chk("fail_req_pll_rst", pll_rst, 1);
                 req = 1'b0;
        at(170); chk("fail_req_ack_pulse", ack, 0);
        at(172); chk("fail_prst_hold", pll_rst, 1);
        at(173); chk("fail_prst_end", pll_rst, 0);
                 pll_locked = 1'b1;

        // reset pulse during STABLE
        at(178); chk("mid_stable", sys_rst_n, 0);
                 rst_n = 1'b0;
        at(179); chk("mid_pll_rst", pll_rst, 1);
                 chk("mid_sys_rst_n", sys_rst_n, 0);
                 chk("mid_ready", ready, 0);
                 chk("mid_fail", fail, 0);
                 chk("mid_ack", ack, 0);
                 chk("mid_retries", retries, 0);
                 rst_n = 1'b1;
        at(182); chk("mid_prst_hold", pll_rst, 1);
        at(183); chk("mid_prst_end", pll_rst, 0);
        at(191); chk("mid_ready_early", ready, 0);
        at(192); chk("mid_ready", ready, 1);
                 chk("mid_sys_rst_n_run", sys_rst_n, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
